// File: rtl/mem_fpga_arbiter.sv
// Two-requester round-robin arbiter in front of a single-port on-chip RAM with a fixed read latency.
// Optional grant/conflict statistics are built in when MEM_ARB_STATS_EN is defined.
module mem_fpga_arbiter #(
    parameter int READ_LATENCY = 2
) (
    input  logic        clk_clk,
    input  logic        reset_reset_n,

    input  logic        r0_req,
    input  logic        r0_write,
    input  logic [9:0]  r0_addr,
    input  logic [31:0] r0_wdata,
    input  logic [3:0]  r0_be,
    output logic        r0_gnt,
    output logic        r0_rvalid,
    output logic [31:0] r0_rdata,

    input  logic        r1_req,
    input  logic        r1_write,
    input  logic [9:0]  r1_addr,
    input  logic [31:0] r1_wdata,
    input  logic [3:0]  r1_be,
    output logic        r1_gnt,
    output logic        r1_rvalid,
    output logic [31:0] r1_rdata,

    output logic [9:0]  mem_address,
    output logic        mem_chipselect,
    output logic        mem_clken,
    output logic        mem_write,
    output logic [31:0] mem_writedata,
    output logic [3:0]  mem_byteenable,
`ifdef MEM_ARB_STATS_EN
    input  logic        stat_clr,
    output logic [15:0] stat_gnt0,
    output logic [15:0] stat_gnt1,
    output logic [15:0] stat_conflict,
`endif
    input  logic [31:0] mem_readdata
);

    // last_grant_r: 1'b1 means r1 was granted most recently, so r0 wins the next contention
    logic                    last_grant_r;
    logic                    gnt0_s;
    logic                    gnt1_s;
    logic                    gnt_any_s;
    logic                    sel_write_s;
    logic [9:0]              sel_addr_s;
    logic [31:0]             sel_wdata_s;
    logic [3:0]              sel_be_s;

    logic [9:0]              mem_address_r;
    logic                    mem_chipselect_r;
    logic                    mem_write_r;
    logic [31:0]             mem_writedata_r;
    logic [3:0]              mem_byteenable_r;

    logic [READ_LATENCY-1:0] tag_valid_r;
    logic [READ_LATENCY-1:0] tag_owner_r;
    logic                    r0_rvalid_r;
    logic                    r1_rvalid_r;

    // Round-robin grant decision; nothing is granted while reset is held
    always_comb begin
        gnt0_s = 1'b0;
        gnt1_s = 1'b0;
        if (!reset_reset_n) begin
            gnt0_s = 1'b0;
            gnt1_s = 1'b0;
        end else if (r0_req && r1_req) begin
            if (last_grant_r) begin
                gnt0_s = 1'b1;
            end else begin
                gnt1_s = 1'b1;
            end
        end else if (r0_req) begin
            gnt0_s = 1'b1;
        end else if (r1_req) begin
            gnt1_s = 1'b1;
        end else begin
            gnt0_s = 1'b0;
            gnt1_s = 1'b0;
        end
    end

    // Select the command fields of the granted requester
    always_comb begin
        sel_write_s = 1'b0;
        sel_addr_s  = 10'd0;
        sel_wdata_s = 32'd0;
        sel_be_s    = 4'd0;
        if (gnt1_s) begin
            sel_write_s = r1_write;
            sel_addr_s  = r1_addr;
            sel_wdata_s = r1_wdata;
            sel_be_s    = r1_be;
        end else begin
            sel_write_s = r0_write;
            sel_addr_s  = r0_addr;
            sel_wdata_s = r0_wdata;
            sel_be_s    = r0_be;
        end
    end

    assign gnt_any_s = gnt0_s | gnt1_s;

    // Remember who was granted last; idle cycles leave it untouched
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            last_grant_r <= 1'b1;
        end else if (gnt_any_s) begin
            last_grant_r <= gnt1_s;
        end else begin
            last_grant_r <= last_grant_r;
        end
    end

    // RAM command register; address/data/enables hold when idle
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            mem_address_r    <= 10'd0;
            mem_chipselect_r <= 1'b0;
            mem_write_r      <= 1'b0;
            mem_writedata_r  <= 32'd0;
            mem_byteenable_r <= 4'd0;
        end else if (gnt_any_s) begin
            mem_address_r    <= sel_addr_s;
            mem_chipselect_r <= 1'b1;
            mem_write_r      <= sel_write_s;
            mem_writedata_r  <= sel_wdata_s;
            mem_byteenable_r <= sel_be_s;
        end else begin
            mem_chipselect_r <= 1'b0;
            mem_write_r      <= 1'b0;
        end
    end

    // Owner tag pipeline: stage 0 lines up with the chipselect cycle, the rvalid register adds the last cycle
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            tag_valid_r <= '0;
            tag_owner_r <= '0;
            r0_rvalid_r <= 1'b0;
            r1_rvalid_r <= 1'b0;
        end else begin
            tag_valid_r[0] <= gnt_any_s & ~sel_write_s;
            tag_owner_r[0] <= gnt1_s;
            for (int i = 1; i < READ_LATENCY; i++) begin
                tag_valid_r[i] <= tag_valid_r[i-1];
                tag_owner_r[i] <= tag_owner_r[i-1];
            end
            r0_rvalid_r <= tag_valid_r[READ_LATENCY-1] & ~tag_owner_r[READ_LATENCY-1];
            r1_rvalid_r <= tag_valid_r[READ_LATENCY-1] &  tag_owner_r[READ_LATENCY-1];
        end
    end

`ifdef MEM_ARB_STATS_EN
    logic [15:0] stat_gnt0_r;
    logic [15:0] stat_gnt1_r;
    logic [15:0] stat_conflict_r;

    function automatic logic [15:0] sat_inc(input logic [15:0] value);
        sat_inc = (value == 16'hFFFF) ? value : value + 16'd1;
    endfunction

    // Saturating statistics counters with synchronous clear
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            stat_gnt0_r     <= 16'd0;
            stat_gnt1_r     <= 16'd0;
            stat_conflict_r <= 16'd0;
        end else if (stat_clr) begin
            stat_gnt0_r     <= 16'd0;
            stat_gnt1_r     <= 16'd0;
            stat_conflict_r <= 16'd0;
        end else begin
            stat_gnt0_r     <= gnt0_s ? sat_inc(stat_gnt0_r) : stat_gnt0_r;
            stat_gnt1_r     <= gnt1_s ? sat_inc(stat_gnt1_r) : stat_gnt1_r;
            stat_conflict_r <= (r0_req && r1_req) ? sat_inc(stat_conflict_r) : stat_conflict_r;
        end
    end

    assign stat_gnt0     = stat_gnt0_r;
    assign stat_gnt1     = stat_gnt1_r;
    assign stat_conflict = stat_conflict_r;
`endif

    assign r0_gnt         = gnt0_s;
    assign r1_gnt         = gnt1_s;
    assign r0_rvalid      = r0_rvalid_r;
    assign r1_rvalid      = r1_rvalid_r;
    assign r0_rdata       = mem_readdata;
    assign r1_rdata       = mem_readdata;
    assign mem_address    = mem_address_r;
    assign mem_chipselect = mem_chipselect_r;
    assign mem_write      = mem_write_r;
    assign mem_writedata  = mem_writedata_r;
    assign mem_byteenable = mem_byteenable_r;
    // Clock enable follows the reset pin directly so it is high for every cycle out of reset
    assign mem_clken      = reset_reset_n;

endmodule
